// File: rtl/t_switch_out_arbiter.sv
// t_switch_out_arbiter
// Credit-aware round-robin arbiter for one T-switch output link.
// Grants at most one requester per cycle among those whose target VC has
// downstream credit, and tracks one credit counter per VC.
// Optional feature macro: T_SWITCH_ARB_CREDIT_CHECK_EN (sticky overflow flag
// plus simulation assertions). Default build ties cred_err to 0.
module t_switch_out_arbiter #(
  parameter  int NUM_REQ       = 2,
  parameter  int VC_W          = 1,
  parameter  int VC_FIFO_DEPTH = 4,
  localparam int CRED_W        = $clog2(VC_FIFO_DEPTH),
  localparam int NUM_VC        = 2**VC_W,
  localparam int SEL_W         = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*VC_W-1:0]  req_vc,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     out_valid,
  output logic [SEL_W-1:0]         out_sel,
  output logic [VC_W-1:0]          out_vc,
  input  logic                     cred_ret_valid,
  input  logic [VC_W-1:0]          cred_ret_vc,
  output logic [NUM_VC*CRED_W-1:0] cred_avail,
  output logic                     cred_err
);

  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(VC_FIFO_DEPTH-1);

  logic [CRED_W-1:0] cred_q [NUM_VC];
  logic [CRED_W-1:0] cred_d [NUM_VC];
  logic [SEL_W-1:0]  rr_q, rr_d;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_VC-1:0]  inc_v, dec_v;
  logic               found;
  int                 idx;

  // Requester is eligible when valid and its target VC holds credit
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] && (cred_q[req_vc[i*VC_W +: VC_W]] != '0);
    end
  end

  // Round-robin search starting at rr_q; outputs forced idle during reset
  always_comb begin
    grant   = '0;
    out_sel = '0;
    out_vc  = '0;
    found   = 1'b0;
    idx     = 0;
    if (!rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!found && elig[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          out_sel    = SEL_W'(idx);
          out_vc     = req_vc[idx*VC_W +: VC_W];
        end
      end
    end
  end

  assign out_valid = found;

  // Per-VC return/consume strobes
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      inc_v[v] = cred_ret_valid && (cred_ret_vc == VC_W'(v));
      dec_v[v] = out_valid && (out_vc == VC_W'(v));
    end
  end

  // Next credit counts: return and consume on the same VC cancel; saturate at max
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      cred_d[v] = cred_q[v];
      if (inc_v[v] && !dec_v[v] && (cred_q[v] != CRED_MAX))
        cred_d[v] = cred_q[v] + CRED_W'(1);
      else if (dec_v[v] && !inc_v[v])
        cred_d[v] = cred_q[v] - CRED_W'(1);
    end
  end

  // Priority moves to the requester after the winner; holds when idle
  always_comb begin
    rr_d = rr_q;
    if (out_valid)
      rr_d = (out_sel == SEL_W'(NUM_REQ-1)) ? '0 : out_sel + SEL_W'(1);
  end

  // Credit and priority state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) cred_q[v] <= CRED_MAX;
      rr_q <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) cred_q[v] <= cred_d[v];
      rr_q <= rr_d;
    end
  end

  // Flatten the credit counters for observation
  always_comb begin
    cred_avail = '0;
    for (int v = 0; v < NUM_VC; v++) cred_avail[v*CRED_W +: CRED_W] = cred_q[v];
  end

`ifdef T_SWITCH_ARB_CREDIT_CHECK_EN
  logic ovf;
  logic err_q;

  assign ovf = !rst && cred_ret_valid && (cred_q[cred_ret_vc] == CRED_MAX) &&
               !(out_valid && (out_vc == cred_ret_vc));

  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)      err_q <= 1'b0;
    else if (ovf) err_q <= 1'b1;
  end

  assign cred_err = err_q;

  // Simulation checks: no credit overflow, grant one-hot or zero
  always @(posedge clk) begin
    if (!rst) begin
      assert (!ovf) else $error("credit overflow on vc %0d", cred_ret_vc);
      assert ($onehot0(grant)) else $error("grant not one-hot: %b", grant);
    end
  end
`else
  assign cred_err = 1'b0;
`endif

endmodule

// File: doc/t_switch_out_arbiter.md
# t_switch_out_arbiter

Credit-aware output-port arbiter for the T-switch. It shares one switch output link (u0_tx, l_tx or r_tx) between NUM_REQ input ports. Each input port requests the link on a specific virtual channel (VC). The block grants at most one requester per cycle, using round-robin order among requesters whose target VC has downstream credit. It also keeps one credit counter per VC, fed by credit returns from the downstream receiver. One instance sits in front of each output port of credit_t_switch_top.

## Interface
Parameters:
- NUM_REQ, 2, number of requesting input ports (2 for up-routing, 3 maximum for down-routing)
- VC_W, DEFAULT_VC_W, VC index width; number of VCs NUM_VC = 2**VC_W
- VC_FIFO_DEPTH, DEFAULT_VC_FIFO_DEPTH, downstream VC FIFO depth; usable credits per VC = VC_FIFO_DEPTH-1
- CRED_W, $clog2(VC_FIFO_DEPTH), credit counter width (derived, not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  NUM_REQ  requester i has a flit for this output
- req_vc  in  NUM_REQ*VC_W  target VC of requester i; packed, slice i = [i*VC_W +: VC_W]
- grant  out  NUM_REQ  one-hot (or zero) grant; the flit of the granted requester transfers this cycle
- out_valid  out  1  a flit is driven onto the link this cycle (= |grant)
- out_sel  out  $clog2(NUM_REQ)  index of the granted requester; 0 when out_valid=0
- out_vc  out  VC_W  VC of the granted flit; 0 when out_valid=0
- cred_ret_valid  in  1  downstream freed one slot
- cred_ret_vc  in  VC_W  VC of the returned credit
- cred_avail  out  NUM_VC*CRED_W  current credit count per VC (registered)
- cred_err  out  1  sticky credit-overflow flag (see Configuration)

## Operation
- Eligible requester i: req_valid[i] && cred[req_vc[i]] != 0.
- Round-robin: the register rr_ptr holds the highest-priority index. The search runs rr_ptr, rr_ptr+1, … modulo NUM_REQ, and the first eligible requester wins.
- When a grant is issued, rr_ptr becomes (winner+1) mod NUM_REQ on the next edge. With no grant, rr_ptr holds.
- A requester holds req_valid and req_vc stable until it is granted. The block does not check this; an ungranted request may be withdrawn.
- Credit update per VC v on each edge: cred[v] += (cred_ret_valid && cred_ret_vc==v) − (out_valid && out_vc==v).
- A simultaneous return and consume on the same VC leaves the count unchanged.
- cred[v]==0 blocks every requester targeting v. Requesters on other VCs remain eligible, so there is no head-of-line blocking across VCs inside this block.
- Return while cred[v]==VC_FIFO_DEPTH-1 with no consume on v is an overflow:
  - The count saturates and does not wrap.
  - Handling of cred_err is set under Configuration.
- Reset:
  - cred[v]=VC_FIFO_DEPTH-1 for all v; rr_ptr=0; cred_err=0.
  - While rst=1: grant=0, out_valid=0, out_sel=0, out_vc=0, and cred_ret_valid is ignored.
  - Reset asserted mid-traffic discards all in-flight credit state. Downstream must be reset in the same cycle.

## Timing
- grant, out_valid, out_sel and out_vc are combinational from req_valid, req_vc and the registered cred/rr_ptr. Latency is zero, so the grant is in the same cycle as the request.
- No combinational path exists from cred_ret_* to grant. A credit returned in cycle t can first enable a grant in cycle t+1.
- Consuming the last credit in cycle t blocks that VC from cycle t+1 until a return is registered.
- cred_avail reflects the state after the previous edge.
- Maximum throughput: one grant per cycle, sustained while credits exist.
- Fairness: with all NUM_REQ requesters continuously eligible, each requester receives exactly one grant every NUM_REQ cycles.

## Configuration
- T_SWITCH_ARB_CREDIT_CHECK_EN defined:
  - An overflow sets cred_err=1 from the next cycle until rst.
  - An immediate SystemVerilog assertion fires in simulation.
  - Also asserted: the grant is one-hot or zero.
- Undefined:
  - cred_err is tied to 0.
  - Overflow silently saturates.
  - No assertions are compiled.

## Test plan
- Reset, NUM_REQ=2, VC_W=1, VC_FIFO_DEPTH=4 -> cred_avail=3 per VC, grant=0 during rst; one cycle after rst falls, a request from req 0 on VC0 is granted the same cycle.
- Both requesters valid on VC0, credits returned every cycle -> grants alternate 0,1,0,1; cred[VC0] holds at 3.
- Req 0 on VC0 alone, no returns -> 3 consecutive grants, then cred[VC0]=0 and grant=0. A return in cycle t -> grant in t+1.
- cred[VC0]=0, req 0 on VC0 and req 1 on VC1 -> req 1 granted every cycle until VC1 is exhausted; req 0 is never granted.
- Return and consume on VC1 in the same cycle at cred=1 -> stays 1; at cred=0 (consume impossible) the return -> 1.
- With T_SWITCH_ARB_CREDIT_CHECK_EN defined, a return at cred=3 -> count stays 3 and cred_err=1 until rst. Without the macro -> cred_err stays 0.
